cache_controller: RTL and testbench
===================================

Name: cache_controller

Overview:
Direct-mapped, write-back, write-allocate cache controller. It sits between the CPU load/store port and the cache tag memory, data memory and main-memory bus. It drives the shared index, consumes the tag block read from the tag memory, decides hit or miss, and sequences write-back and refill. After reset it sweeps the tag memory to invalidate every line.

Parameters:
ADDR_W, 32, byte address width
OFFSET_W, 2, byte-offset bits (one 32-bit word per line)
IDX_W, 5, index bits; IDX_SIZE = 2**IDX_W lines
DATA_W, 32, data word width
TAG_W (localparam), ADDR_W-IDX_W-OFFSET_W = 25, tag width
TAG_MEM_W (localparam), TAG_W+2 = 27; layout {valid[26], dirty[25], tag[24:0]}

Ports:
iCLK  in  1  clock; all state updates on the rising edge
iRST  in  1  synchronous, active-high reset
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  store data
cpu_ready  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  load data, valid while cpu_ready=1 for a load
tag_we  out  1  tag memory write enable
idx  out  IDX_W  index to tag and data memories
tag_block_in  out  TAG_MEM_W  tag block to write
tag_block_out  in  TAG_MEM_W  asynchronous tag read at idx
data_we  out  1  data memory write enable
data_in  out  DATA_W  data word to write
data_out  in  DATA_W  asynchronous data read at idx
mem_req  out  1  main-memory request, held until mem_ack
mem_we  out  1  1 = write-back, 0 = refill read
mem_addr  out  ADDR_W  word-aligned memory address (offset bits = 0)
mem_wdata  out  DATA_W  write-back data
mem_ack  in  1  memory done; mem_rdata valid in the same cycle
mem_rdata  in  DATA_W  refill data

Behaviour:
- States: INIT, IDLE, COMPARE, WRITEBACK, ALLOCATE.
- Reset:
  - iRST=1 at an edge sets state=INIT and the init counter to 0.
  - While iRST=1, cpu_ready, tag_we, data_we and mem_req are forced to 0.
  - Reset mid-operation abandons any request; mem_req drops in the reset cycle.
- Request latch: in IDLE, cpu_req=1 at an edge latches cpu_addr, cpu_we and cpu_wdata into req_* registers and moves to COMPARE. Inputs are ignored in all other states.
- Address split: tag=req_addr[ADDR_W-1:IDX_W+OFFSET_W], index=req_addr[IDX_W+OFFSET_W-1:OFFSET_W]. idx shows the latched index outside INIT.
- INIT:
  - idx=counter, tag_we=1, tag_block_in=0.
  - Counter increments each cycle; after writing index IDX_SIZE-1 (32 cycles), go to IDLE.
  - cpu_ready=0 throughout.
- IDLE: all enables 0; cpu_ready=0.
- COMPARE:
  - hit = tag_block_out[26] and tag_block_out[24:0]==req tag.
  - Load hit: cpu_ready=1, cpu_rdata=data_out, then IDLE.
  - Store hit: data_we=1, data_in=req_wdata, tag_we=1, tag_block_in={1,1,tag}, cpu_ready=1, then IDLE.
  - Miss with valid and dirty: go to WRITEBACK. Any other miss: go to ALLOCATE.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={stored tag, index, 2'b00}, mem_wdata=data_out.
  - On mem_ack, go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr={req tag, index, 2'b00}.
  - On mem_ack: data_we=1, data_in=mem_rdata, tag_we=1, tag_block_in={1,0,tag}, then COMPARE. The re-compare hits and completes the access; a store then sets dirty.
- Latency:
  - Hit: cpu_ready in the cycle after acceptance (acceptance edge + 1 cycle).
  - Clean miss: +1 ALLOCATE cycle per memory wait cycle, +1 COMPARE.
  - Dirty miss: adds the WRITEBACK cycles.
- Boundaries:
  - mem_ack while not in WRITEBACK or ALLOCATE is ignored.
  - cpu_req held high after cpu_ready is accepted as a new request from IDLE on the following edge.
  - A tag match with valid=0 is a miss.
  - Index IDX_SIZE-1 behaves like any other line.
- cpu_rdata is 0 whenever cpu_ready=0 or the access is a store.

Test Plan:
- Reset, then hold cpu_req=1 -> tag_we=1 for 32 cycles with idx 0..31 and tag_block_in=0; first cpu_ready no earlier than cycle 34.
- Load 0x0000_0040 cold, memory returns 0xDEADBEEF after 3 wait cycles -> mem_addr=0x40, mem_we=0; tag block 0x4000000 written at idx 16; cpu_ready with cpu_rdata=0xDEADBEEF.
- Repeat load 0x40 -> hit, no mem_req, cpu_ready one cycle after acceptance.
- Store 0x12345678 to 0x40 -> hit, tag_block_in dirty bit set, data_we=1. Then load 0x1040 (same idx 16, tag 0x20) -> write-back with mem_addr=0x40, mem_wdata=0x12345678, followed by refill from 0x1040.
- Assert iRST during ALLOCATE with mem_req=1 -> mem_req=0 that cycle, state restarts INIT sweep, no cpu_ready.
- Store miss to a clean line -> refill, then tag_block_in={1,1,tag} and data_in=cpu_wdata on re-compare.

Source files
------------

// File: rtl/cache_controller_if.sv
// Bus bundle between the cache controller and its CPU port, tag/data memories
// and the main-memory port. master = controller side, slave = environment side.
interface cache_controller_if #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 2,
   parameter int IDX_W    = 5,
   parameter int DATA_W   = 32
);
   localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W;
   localparam int TAG_MEM_W = TAG_W + 2;

   logic                 cpu_req;
   logic                 cpu_we;
   logic [ADDR_W-1:0]    cpu_addr;
   logic [DATA_W-1:0]    cpu_wdata;
   logic                 cpu_ready;
   logic [DATA_W-1:0]    cpu_rdata;

   logic                 tag_we;
   logic [IDX_W-1:0]     idx;
   logic [TAG_MEM_W-1:0] tag_block_in;
   logic [TAG_MEM_W-1:0] tag_block_out;

   logic                 data_we;
   logic [DATA_W-1:0]    data_in;
   logic [DATA_W-1:0]    data_out;

   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic                 mem_ack;
   logic [DATA_W-1:0]    mem_rdata;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_ready, cpu_rdata,
      output tag_we, idx, tag_block_in,
      input  tag_block_out,
      output data_we, data_in,
      input  data_out,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_ready, cpu_rdata,
      input  tag_we, idx, tag_block_in,
      output tag_block_out,
      input  data_we, data_in,
      output data_out,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache controller with a
// post-reset sweep that invalidates every tag entry.
module cache_controller #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 2,
   parameter int IDX_W    = 5,
   parameter int DATA_W   = 32
) (
   input  logic               iCLK,
   input  logic               iRST,
   cache_controller_if.master bus
);
   localparam int TAG_W     = ADDR_W - IDX_W - OFFSET_W;
   localparam int TAG_MEM_W = TAG_W + 2;

   localparam logic [2:0] INIT      = 3'd0;
   localparam logic [2:0] IDLE      = 3'd1;
   localparam logic [2:0] COMPARE   = 3'd2;
   localparam logic [2:0] WRITEBACK = 3'd3;
   localparam logic [2:0] ALLOCATE  = 3'd4;

   logic [2:0]       state, next_state;
   logic [IDX_W-1:0] init_cnt;

   logic [TAG_W-1:0]  req_tag;
   logic [IDX_W-1:0]  req_idx;
   logic              req_we;
   logic [DATA_W-1:0] req_wdata;

   logic             stored_valid, stored_dirty, hit;
   logic [TAG_W-1:0] stored_tag;
   logic             unused_offset;

   // Lines are one word wide, so the byte offset never selects anything.
   assign unused_offset = ^bus.cpu_addr[OFFSET_W-1:0];

   assign stored_valid = bus.tag_block_out[TAG_MEM_W-1];
   assign stored_dirty = bus.tag_block_out[TAG_MEM_W-2];
   assign stored_tag   = bus.tag_block_out[TAG_W-1:0];
   assign hit          = stored_valid && (stored_tag == req_tag);

   always_comb begin
      next_state = state;
      case (state)
         INIT:      if (init_cnt == {IDX_W{1'b1}}) next_state = IDLE;
         IDLE:      if (bus.cpu_req) next_state = COMPARE;
         COMPARE: begin
            if (hit)                               next_state = IDLE;
            else if (stored_valid && stored_dirty) next_state = WRITEBACK;
            else                                   next_state = ALLOCATE;
         end
         WRITEBACK: if (bus.mem_ack) next_state = ALLOCATE;
         ALLOCATE:  if (bus.mem_ack) next_state = COMPARE;
         default:   next_state = INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state    <= INIT;
         init_cnt <= '0;
      end else begin
         state <= next_state;
         if (state == INIT) init_cnt <= init_cnt + 1'b1;
      end
   end

   // NOTE: request registers carry no reset; they are only consumed after
   // being loaded in IDLE, so resetting them would add logic for nothing.
   always_ff @(posedge iCLK) begin
      if (state == IDLE && bus.cpu_req) begin
         req_tag   <= bus.cpu_addr[ADDR_W-1:IDX_W+OFFSET_W];
         req_idx   <= bus.cpu_addr[IDX_W+OFFSET_W-1:OFFSET_W];
         req_we    <= bus.cpu_we;
         req_wdata <= bus.cpu_wdata;
      end
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      bus.cpu_ready    = 1'b0;
      bus.cpu_rdata    = '0;
      bus.tag_we       = 1'b0;
      bus.idx          = (state == INIT) ? init_cnt : req_idx;
      bus.tag_block_in = '0;
      bus.data_we      = 1'b0;
      bus.data_in      = '0;
      bus.mem_req      = 1'b0;
      bus.mem_we       = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      if (!iRST) begin
         case (state)
            INIT: bus.tag_we = 1'b1;
            COMPARE: begin
               if (hit) begin
                  bus.cpu_ready = 1'b1;
                  if (req_we) begin
                     bus.data_we      = 1'b1;
                     bus.data_in      = req_wdata;
                     bus.tag_we       = 1'b1;
                     bus.tag_block_in = {1'b1, 1'b1, req_tag};
                  end else begin
                     bus.cpu_rdata = bus.data_out;
                  end
               end
            end
            WRITEBACK: begin
               bus.mem_req   = 1'b1;
               bus.mem_we    = 1'b1;
               bus.mem_addr  = {stored_tag, req_idx, {OFFSET_W{1'b0}}};
               bus.mem_wdata = bus.data_out;
            end
            ALLOCATE: begin
               bus.mem_req  = 1'b1;
               bus.mem_addr = {req_tag, req_idx, {OFFSET_W{1'b0}}};
               if (bus.mem_ack) begin
                  // Refill lands clean; a pending store dirties it on re-compare.
                  bus.data_we      = 1'b1;
                  bus.data_in      = bus.mem_rdata;
                  bus.tag_we       = 1'b1;
                  bus.tag_block_in = {1'b1, 1'b0, req_tag};
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: behavioural tag/data memories plus a
// hand-driven main-memory responder with hand-computed expectations.
module tb_cache_controller;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   cache_controller_if bus ();

   cache_controller dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus.master)
   );

   logic [26:0] tag_mem  [32];
   logic [31:0] data_mem [32];

   initial begin
      for (int i = 0; i < 32; i++) begin
         tag_mem[i]  = 27'h7FF_FFFF;
         data_mem[i] = 32'h0;
      end
   end

   always @(posedge clk) begin
      if (bus.tag_we)  tag_mem[bus.idx]  <= bus.tag_block_in;
      if (bus.data_we) data_mem[bus.idx] <= bus.data_in;
   end

   assign bus.tag_block_out = tag_mem[bus.idx];
   assign bus.data_out      = data_mem[bus.idx];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   // Presents one request from IDLE and returns at the first COMPARE cycle.
   task automatic access_start(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      @(negedge clk);
      bus.cpu_req = 1'b0;
   endtask

   // Serves one memory transaction after `waits` stall cycles.
   task automatic mem_serve(input string name, input logic exp_we, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input int waits,
                            input logic [31:0] rdata, input logic [26:0] exp_tag_block);
      int n = 0;
      while (!bus.mem_req && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_mem_req"}, bus.mem_req, 1);
      if (!bus.mem_req) return;
      check({name, "_mem_we"}, bus.mem_we, exp_we);
      check({name, "_mem_addr"}, bus.mem_addr, exp_addr);
      if (exp_we) check({name, "_mem_wdata"}, bus.mem_wdata, exp_wdata);
      repeat (waits) begin
         @(negedge clk);
         check({name, "_mem_hold"}, bus.mem_req, 1);
      end
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      #1;
      if (!exp_we) begin
         check({name, "_fill_data_we"}, bus.data_we, 1);
         check({name, "_fill_data_in"}, bus.data_in, rdata);
         check({name, "_fill_tag_we"}, bus.tag_we, 1);
         check({name, "_fill_tag_block"}, bus.tag_block_in, exp_tag_block);
      end
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      #1;
   endtask

   task automatic wait_ready(input string name, input logic [31:0] exp_rdata);
      int n = 0;
      while (!bus.cpu_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready"}, bus.cpu_ready, 1);
      check({name, "_rdata"}, bus.cpu_rdata, exp_rdata);
   endtask

   initial begin
      int ready_seen;
      rst           = 1'b1;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_tag_we", bus.tag_we, 0);
      check("rst_cpu_ready", bus.cpu_ready, 0);
      check("rst_mem_req", bus.mem_req, 0);

      // Init sweep with cpu_req held: the held request becomes a cold load of 0x40.
      rst          = 1'b0;
      bus.cpu_req  = 1'b1;
      bus.cpu_addr = 32'h0000_0040;
      #1;
      for (int k = 0; k < 32; k++) begin
         check("init_tag_we", bus.tag_we, 1);
         check("init_idx", bus.idx, k);
         check("init_tag_block", bus.tag_block_in, 0);
         check("init_cpu_ready", bus.cpu_ready, 0);
         @(negedge clk);
      end
      check("idle_tag_we", bus.tag_we, 0);
      check("idle_cpu_ready", bus.cpu_ready, 0);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      check("cold_compare_ready", bus.cpu_ready, 0);
      mem_serve("cold", 1'b0, 32'h40, 32'h0, 3, 32'hDEAD_BEEF, 27'h400_0000);
      check("cold_fill_idx16", tag_mem[16], 27'h400_0000);
      wait_ready("cold", 32'hDEAD_BEEF);
      @(negedge clk);

      // Load hit: ready exactly one cycle after acceptance.
      access_start(1'b0, 32'h40, 32'h0);
      check("hit_ready", bus.cpu_ready, 1);
      check("hit_rdata", bus.cpu_rdata, 32'hDEAD_BEEF);
      check("hit_mem_req", bus.mem_req, 0);
      @(negedge clk);

      // Store hit sets dirty.
      access_start(1'b1, 32'h40, 32'h1234_5678);
      check("st_ready", bus.cpu_ready, 1);
      check("st_rdata", bus.cpu_rdata, 0);
      check("st_data_we", bus.data_we, 1);
      check("st_data_in", bus.data_in, 32'h1234_5678);
      check("st_tag_block", bus.tag_block_in, 27'h600_0000);
      @(negedge clk);

      // Conflict load 0x1040 -> write-back of 0x40 then refill.
      access_start(1'b0, 32'h1040, 32'h0);
      check("wb_compare_ready", bus.cpu_ready, 0);
      mem_serve("wb", 1'b1, 32'h40, 32'h1234_5678, 1, 32'h0, 27'h0);
      mem_serve("wbfill", 1'b0, 32'h1040, 32'h0, 0, 32'hCAFE_F00D, 27'h400_0020);
      wait_ready("wbfill", 32'hCAFE_F00D);
      @(negedge clk);

      // Last index; the invalidated entry's tag field (0) matches but is a miss.
      access_start(1'b0, 32'h7C, 32'h0);
      check("idx31_idx", bus.idx, 31);
      mem_serve("idx31", 1'b0, 32'h7C, 32'h0, 2, 32'h1111_2222, 27'h400_0000);
      wait_ready("idx31", 32'h1111_2222);
      @(negedge clk);

      // Store miss to a clean line.
      access_start(1'b1, 32'h84, 32'hA5A5_A5A5);
      mem_serve("stmiss", 1'b0, 32'h84, 32'h0, 1, 32'h0000_5555, 27'h400_0001);
      wait_ready("stmiss", 32'h0);
      check("stmiss_tag_block", bus.tag_block_in, 27'h600_0001);
      check("stmiss_data_in", bus.data_in, 32'hA5A5_A5A5);
      check("stmiss_data_we", bus.data_we, 1);
      @(negedge clk);

      // Stray mem_ack in IDLE is ignored.
      bus.mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      bus.mem_ack = 1'b0;
      check("stray_mem_req", bus.mem_req, 0);
      check("stray_tag_we", bus.tag_we, 0);

      // cpu_req held high: back-to-back hits on 0x1040.
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h1040;
      @(negedge clk);
      check("held_ready1", bus.cpu_ready, 1);
      check("held_rdata1", bus.cpu_rdata, 32'hCAFE_F00D);
      @(negedge clk);
      check("held_gap", bus.cpu_ready, 0);
      @(negedge clk);
      bus.cpu_req = 1'b0;
      check("held_ready2", bus.cpu_ready, 1);
      @(negedge clk);

      // Reset in the middle of ALLOCATE.
      access_start(1'b0, 32'h2040, 32'h0);
      @(negedge clk);
      check("rstalloc_mem_req", bus.mem_req, 1);
      check("rstalloc_mem_addr", bus.mem_addr, 32'h2040);
      rst = 1'b1;
      #1;
      check("rstalloc_drop", bus.mem_req, 0);
      check("rstalloc_ready", bus.cpu_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstalloc_init_tag_we", bus.tag_we, 1);
      check("rstalloc_init_idx", bus.idx, 0);
      ready_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.cpu_ready) ready_seen++;
      end
      check("rstalloc_no_ready", ready_seen, 0);
      check("rstalloc_idle_tag_we", bus.tag_we, 0);

      // The sweep invalidated line 16, so 0x40 misses again.
      access_start(1'b0, 32'h40, 32'h0);
      mem_serve("reinit", 1'b0, 32'h40, 32'h0, 0, 32'h7777_0000, 27'h400_0000);
      wait_ready("reinit", 32'h7777_0000);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation timeout");
   end
endmodule
